uart_host_ctrl: RTL and testbench
=================================

# uart_host_ctrl

Bus-master sequencer for the UART 16550 register file. On request it programs the divisor latch, line control and FIFO control in the required DLAB order. It then runs a continuous service loop that polls LSR, drains received bytes into a one-entry output buffer, and writes transmit bytes into THR under credit-based flow control. It sits between the host/stream logic and the register interface (wr/rd/addr/din/dout) and is the only master on that interface.

## Interface
- TX_CREDITS, 16: TX FIFO depth. Sets the initial and maximum transmit credit count (1..255).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; begins (or restarts) the configuration sequence
- cfg_div  in  16  baud divisor, sampled on cfg_start
- cfg_lcr  in  7  LCR[6:0] line format, sampled on cfg_start; DLAB is supplied by the block
- cfg_fcr  in  8  FCR value, sampled on cfg_start
- cfg_done  out  1  level; 1 once configuration completes, 0 in IDLE and during configuration
- tx_valid  in  1  TX byte offered; once high, must stay high with tx_data stable until tx_ready
- tx_data  in  8  TX byte
- tx_ready  out  1  one-cycle accept strobe for the TX byte
- tx_credit_ret  in  1  pulse; the transmitter popped one TX FIFO entry
- rx_valid  out  1  RX buffer holds a byte
- rx_data  out  8  RX byte
- rx_ready  in  1  consumer accepts; the handshake completes when rx_valid & rx_ready
- err  out  1  sticky; set if any polled LSR has bit 1..4 set; cleared by rst or cfg_start
- err_bits  out  4  sticky OR of LSR[4:1] (bi, fe, pe, oe)
- bus_wr  out  1  register write strobe
- bus_rd  out  1  register read strobe
- bus_addr  out  3  register address
- bus_wdata  out  8  register write data
- bus_rdata  in  8  register read data

## Operation
- States: IDLE, C_LCRD, C_DLL, C_DLM, C_LCR, C_FCR, POLL_RD, POLL_W, POLL_S, RX_RD, RX_W, RX_S, TX_WR.
- Configuration sequence (one write per cycle, in this order):
  - C_LCRD: write addr 3, data {1, lcr}
  - C_DLL: write addr 0, data div[7:0]
  - C_DLM: write addr 1, data div[15:8]
  - C_LCR: write addr 3, data {0, lcr}
  - C_FCR: write addr 2, data fcr | 8'h06 (both FIFO resets forced)
- After C_FCR: go to POLL_RD; set cfg_done; reload credits to TX_CREDITS.
- Read protocol: bus_rd=1 with the address in the *_RD cycle; the address is held with bus_rd=0 in the *_W cycle; bus_rdata is sampled in the *_S cycle.
- POLL reads addr 5 (LSR). In POLL_S:
  - err_bits |= rdata[4:1]
  - rx_elig = rdata[0] & ~rx_valid
  - tx_elig = tx_valid & rdata[5] & (credits != 0)
- Next state from POLL_S:
  - both eligible: serve the class not served last (round-robin flag, reset value = TX last, so RX wins first)
  - one eligible: serve it
  - none eligible: return to POLL_RD
- RX path: RX_RD reads addr 0. In RX_S, rx_data <= rdata and rx_valid <= 1. Then go to POLL_RD.
- TX path: in TX_WR, bus_wr=1, bus_addr=0, bus_wdata=tx_data, tx_ready=1, credits--. Then go to POLL_RD.
- Credits (8 bits):
  - tx_credit_ret increments, saturating at TX_CREDITS.
  - A decrement and a return in the same cycle leave the count unchanged.
- cfg_start is honoured in any state. The current bus access is abandoned and the next cycle is C_LCRD.
- cfg_start also clears err, err_bits, rx_valid, cfg_done and the round-robin flag.
- In IDLE (after rst), the block makes no bus accesses.

## Timing
- Reset values:
  - state IDLE
  - all bus strobes 0; bus_addr 0; bus_wdata 0
  - tx_ready 0; rx_valid 0; rx_data 0
  - cfg_done 0; err 0; err_bits 0
  - credits TX_CREDITS
- bus_* outputs and tx_ready decode from the state register only (plus tx_data in TX_WR). They change on the clock edge after the decision.
- Configuration latency: cfg_start at cycle T gives writes at T+1..T+5; cfg_done=1 from T+6 and the first POLL_RD at T+6.
- Per-byte cost: poll 3 cycles, then +1 cycle for TX or +3 cycles for RX. Minimum TX period is 4 cycles; minimum RX period is 6 cycles.
- rx_valid rises in the cycle after RX_S and stays high until the handshake. It clears on the edge after rx_valid & rx_ready.
- rst asserted mid-sequence returns to IDLE on the next edge. A partially written configuration is not resumed.

## Test plan
- Configure with div=16'h0145, lcr=7'h03, fcr=8'hC1 -> bus writes (3,83),(0,45),(1,01),(3,03),(2,C7) on five consecutive cycles; cfg_done high on the 6th cycle.
- After configuration, hold tx_valid with data A5, LSR model=60 -> bus write (0,A5) with tx_ready in the 4th cycle after the poll starts; credits 16->15.
- Stream 16 TX bytes with no tx_credit_ret -> exactly 16 writes, then polling continues with tx_ready low; one tx_credit_ret -> one more write.
- LSR=61, RBR=3C, rx_ready=0 -> rx_valid=1 with rx_data=3C; further polls with DR=1 issue no addr-0 reads until rx_ready is pulsed.
- LSR=61 with tx_valid high continuously -> RX and TX services alternate, RX first. LSR=69 once -> err=1, err_bits=4'b0100, held until cfg_start.
- rst during C_DLM and cfg_start during RX_W -> IDLE with all outputs at reset values, and a fresh sequence starting at C_LCRD, respectively.

Source files
------------

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: sole bus master for a 16550 register file. It programs the divisor,
// line and FIFO control in DLAB order, then polls LSR to service RX and credit-limited TX.
module uart_host_ctrl #(
   parameter int TX_CREDITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_start,
   input  logic [15:0] cfg_div,
   input  logic [6:0]  cfg_lcr,
   input  logic [7:0]  cfg_fcr,
   output logic        cfg_done,
   input  logic        tx_valid,
   input  logic [7:0]  tx_data,
   output logic        tx_ready,
   input  logic        tx_credit_ret,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic        err,
   output logic [3:0]  err_bits,
   output logic        bus_wr,
   output logic        bus_rd,
   output logic [2:0]  bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata
);

   typedef enum logic [3:0] {
      IDLE, C_LCRD, C_DLL, C_DLM, C_LCR, C_FCR,
      POLL_RD, POLL_W, POLL_S, RX_RD, RX_W, RX_S, TX_WR
   } state_t;

   localparam logic [7:0] CREDIT_MAX = 8'(TX_CREDITS);
   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_DLM   = 3'd1;
   localparam logic [2:0] ADDR_FCR   = 3'd2;
   localparam logic [2:0] ADDR_LCR   = 3'd3;
   localparam logic [2:0] ADDR_LSR   = 3'd5;

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [6:0]  lcr_q, lcr_d;
   logic [7:0]  fcr_q, fcr_d;
   logic [7:0]  credits_q, credits_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        cfg_done_q, cfg_done_d;
   logic        err_q, err_d;
   logic [3:0]  err_bits_q, err_bits_d;
   logic        last_tx_q, last_tx_d;
   logic        rx_elig, tx_elig;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      lcr_d      = lcr_q;
      fcr_d      = fcr_q;
      credits_d  = credits_q;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      cfg_done_d = cfg_done_q;
      err_d      = err_q;
      err_bits_d = err_bits_q;
      last_tx_d  = last_tx_q;
      rx_elig    = bus_rdata[0] & ~rx_valid_q;
      tx_elig    = tx_valid & bus_rdata[5] & (credits_q != 8'd0);

      // A spend and a return in the same cycle cancel out.
      if ((state_q == TX_WR) && !tx_credit_ret) begin
         if (credits_q != 8'd0) credits_d = credits_q - 8'd1;
      end else if (tx_credit_ret && (state_q != TX_WR)) begin
         if (credits_q < CREDIT_MAX) credits_d = credits_q + 8'd1;
      end

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      case (state_q)
         IDLE:    state_d = IDLE;
         C_LCRD:  state_d = C_DLL;
         C_DLL:   state_d = C_DLM;
         C_DLM:   state_d = C_LCR;
         C_LCR:   state_d = C_FCR;
         C_FCR: begin
            state_d    = POLL_RD;
            cfg_done_d = 1'b1;
            credits_d  = CREDIT_MAX;
         end
         POLL_RD: state_d = POLL_W;
         POLL_W:  state_d = POLL_S;
         POLL_S: begin
            err_bits_d = err_bits_q | bus_rdata[4:1];
            err_d      = err_q | (|bus_rdata[4:1]);
            // When both classes are ready, serve whichever did not go last.
            if (rx_elig && (!tx_elig || last_tx_q)) begin
               state_d   = RX_RD;
               last_tx_d = 1'b0;
            end else if (tx_elig) begin
               state_d   = TX_WR;
               last_tx_d = 1'b1;
            end else begin
               state_d = POLL_RD;
            end
         end
         RX_RD:   state_d = RX_W;
         RX_W:    state_d = RX_S;
         RX_S: begin
            rx_data_d  = bus_rdata;
            rx_valid_d = 1'b1;
            state_d    = POLL_RD;
         end
         TX_WR:   state_d = POLL_RD;
         default: state_d = IDLE;
      endcase

      // A configuration request preempts whatever access is in flight.
      if (cfg_start) begin
         state_d    = C_LCRD;
         div_d      = cfg_div;
         lcr_d      = cfg_lcr;
         fcr_d      = cfg_fcr;
         err_d      = 1'b0;
         err_bits_d = 4'd0;
         rx_valid_d = 1'b0;
         cfg_done_d = 1'b0;
         last_tx_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         div_q      <= 16'd0;
         lcr_q      <= 7'd0;
         fcr_q      <= 8'd0;
         credits_q  <= CREDIT_MAX;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'd0;
         cfg_done_q <= 1'b0;
         err_q      <= 1'b0;
         err_bits_q <= 4'd0;
         last_tx_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         lcr_q      <= lcr_d;
         fcr_q      <= fcr_d;
         credits_q  <= credits_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         cfg_done_q <= cfg_done_d;
         err_q      <= err_d;
         err_bits_q <= err_bits_d;
         last_tx_q  <= last_tx_d;
      end
   end

   // Bus strobes decode from the state register alone, so they follow each decision by one edge.
   always_comb begin
      bus_wr    = 1'b0;
      bus_rd    = 1'b0;
      bus_addr  = 3'd0;
      bus_wdata = 8'd0;
      tx_ready  = 1'b0;
      case (state_q)
         C_LCRD: begin bus_wr = 1'b1; bus_addr = ADDR_LCR;  bus_wdata = {1'b1, lcr_q};   end
         C_DLL:  begin bus_wr = 1'b1; bus_addr = ADDR_DATA; bus_wdata = div_q[7:0];      end
         C_DLM:  begin bus_wr = 1'b1; bus_addr = ADDR_DLM;  bus_wdata = div_q[15:8];     end
         C_LCR:  begin bus_wr = 1'b1; bus_addr = ADDR_LCR;  bus_wdata = {1'b0, lcr_q};   end
         C_FCR:  begin bus_wr = 1'b1; bus_addr = ADDR_FCR;  bus_wdata = fcr_q | 8'h06;   end
         POLL_RD: begin bus_rd = 1'b1; bus_addr = ADDR_LSR; end
         POLL_W, POLL_S: bus_addr = ADDR_LSR;
         RX_RD:  begin bus_rd = 1'b1; bus_addr = ADDR_DATA; end
         RX_W, RX_S: bus_addr = ADDR_DATA;
         TX_WR: begin
            bus_wr    = 1'b1;
            bus_addr  = ADDR_DATA;
            bus_wdata = tx_data;
            tx_ready  = 1'b1;
         end
         default: bus_addr = 3'd0;
      endcase
   end

   assign cfg_done = cfg_done_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign err      = err_q;
   assign err_bits = err_bits_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Testbench for uart_host_ctrl: directed configuration/TX/RX/error/reset steps, then
// randomized LSR polling checked against a poll-level service model.
module tb_uart_host_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_start;
   logic [15:0] cfg_div;
   logic [6:0]  cfg_lcr;
   logic [7:0]  cfg_fcr;
   logic        cfg_done;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        tx_credit_ret;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        err;
   logic [3:0]  err_bits;
   logic        bus_wr;
   logic        bus_rd;
   logic [2:0]  bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;

   logic [7:0]  lsr_model;
   logic [7:0]  rbr_model;

   int errors = 0;
   int checks = 0;

   uart_host_ctrl #(.TX_CREDITS(16)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_div(cfg_div),
      .cfg_lcr(cfg_lcr), .cfg_fcr(cfg_fcr), .cfg_done(cfg_done),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .tx_credit_ret(tx_credit_ret), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .err(err), .err_bits(err_bits), .bus_wr(bus_wr),
      .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // The register file answers LSR at address 5 and RBR everywhere else.
   assign bus_rdata = (bus_addr == 3'd5) ? lsr_model : rbr_model;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_bus_wr"}, 16'(bus_wr), 16'd0);
      checkOutput({tag, "_bus_rd"}, 16'(bus_rd), 16'd0);
      checkOutput({tag, "_bus_addr"}, 16'(bus_addr), 16'd0);
      checkOutput({tag, "_bus_wdata"}, 16'(bus_wdata), 16'd0);
      checkOutput({tag, "_tx_ready"}, 16'(tx_ready), 16'd0);
      checkOutput({tag, "_rx_valid"}, 16'(rx_valid), 16'd0);
      checkOutput({tag, "_rx_data"}, 16'(rx_data), 16'd0);
      checkOutput({tag, "_cfg_done"}, 16'(cfg_done), 16'd0);
      checkOutput({tag, "_err"}, 16'(err), 16'd0);
      checkOutput({tag, "_err_bits"}, 16'(err_bits), 16'd0);
   endtask

   // Pulses cfg_start at the current cycle and checks the five ordered writes plus the first poll.
   task automatic applyStimulus(input logic [15:0] div, input logic [6:0] lcr, input logic [7:0] fcr);
      logic [2:0] exp_addr [5];
      logic [7:0] exp_data [5];
      exp_addr = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2};
      exp_data = '{{1'b1, lcr}, div[7:0], div[15:8], {1'b0, lcr}, fcr | 8'h06};
      cfg_div   = div;
      cfg_lcr   = lcr;
      cfg_fcr   = fcr;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      checkOutput("cfg_clr_err", {11'd0, err, err_bits}, 16'd0);
      checkOutput("cfg_clr_rx_valid", 16'(rx_valid), 16'd0);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("cfg_wr%0d_strobe", i), {14'd0, bus_wr, cfg_done}, 16'b10);
         checkOutput($sformatf("cfg_wr%0d_addr", i), 16'(bus_addr), 16'(exp_addr[i]));
         checkOutput($sformatf("cfg_wr%0d_data", i), 16'(bus_wdata), 16'(exp_data[i]));
         step();
      end
      checkOutput("cfg_done_set", 16'(cfg_done), 16'd1);
      checkOutput("cfg_first_poll", {12'd0, bus_rd, bus_addr}, {12'd0, 1'b1, 3'd5});
   endtask

   task automatic waitPoll(input string tag);
      for (int i = 0; i < 12; i++) begin
         if (bus_rd && bus_addr == 3'd5) return;
         step();
      end
      checkOutput({tag, "_poll_timeout"}, 16'd0, 16'd1);
   endtask

   initial begin
      int cnt;
      int n;
      int order [8];
      int svc;
      logic [7:0] l;
      logic       m_rx_full;
      logic [7:0] m_rx_byte;
      int         m_credits;
      logic       m_last_tx;
      logic [3:0] m_err;
      logic       rx_e, tx_e;

      rst = 1'b1; cfg_start = 1'b0; cfg_div = 16'd0; cfg_lcr = 7'd0; cfg_fcr = 8'd0;
      tx_valid = 1'b0; tx_data = 8'd0; tx_credit_ret = 1'b0; rx_ready = 1'b0;
      lsr_model = 8'h00; rbr_model = 8'h00;

      // Reset and idle behaviour.
      step(); step();
      checkResetState("reset");
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus_rd || bus_wr) cnt++;
      end
      checkOutput("idle_no_bus", 16'(cnt), 16'd0);

      // Configuration then the first TX byte.
      applyStimulus(16'h0145, 7'h03, 8'hC1);
      lsr_model = 8'h60; tx_valid = 1'b1; tx_data = 8'hA5;
      step(); step(); step();
      checkOutput("tx_first_strobes", {14'd0, bus_wr, tx_ready}, 16'b11);
      checkOutput("tx_first_addr", 16'(bus_addr), 16'd0);
      checkOutput("tx_first_data", 16'(bus_wdata), 16'hA5);

      // Credit exhaustion: 16 writes total from a full pool.
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         step();
         if (tx_ready && bus_wr) cnt++;
      end
      checkOutput("tx_stream_count", 16'(cnt), 16'd16);
      checkOutput("tx_stalled_ready", 16'(tx_ready), 16'd0);
      tx_credit_ret = 1'b1; step(); tx_credit_ret = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx_ready) cnt++;
      end
      checkOutput("tx_one_return", 16'(cnt), 16'd1);

      // A return coinciding with the write keeps the credit for one more byte.
      tx_credit_ret = 1'b1; step(); tx_credit_ret = 1'b0;
      for (int i = 0; i < 12 && !tx_ready; i++) step();
      checkOutput("tx_sim_seen", 16'(tx_ready), 16'd1);
      tx_credit_ret = 1'b1; step(); tx_credit_ret = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx_ready) cnt++;
      end
      checkOutput("tx_sim_ret_count", 16'(cnt), 16'd1);
      tx_valid = 1'b0;

      // RX into the one-entry buffer with backpressure.
      waitPoll("rx");
      lsr_model = 8'h61; rbr_model = 8'h3C; rx_ready = 1'b0;
      step(); step(); step();
      checkOutput("rx_rd", {12'd0, bus_rd, bus_addr}, {12'd0, 1'b1, 3'd0});
      step(); step(); step();
      checkOutput("rx_valid_set", 16'(rx_valid), 16'd1);
      checkOutput("rx_data", 16'(rx_data), 16'h3C);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus_rd && bus_addr == 3'd0) cnt++;
      end
      checkOutput("rx_full_no_reads", 16'(cnt), 16'd0);
      rx_ready = 1'b1; step(); rx_ready = 1'b0;
      checkOutput("rx_handshake_clr", 16'(rx_valid), 16'd0);

      // Round-robin after a fresh configuration: RX first, then alternating.
      applyStimulus(16'h0145, 7'h03, 8'hC1);
      lsr_model = 8'h61; rbr_model = 8'h11; tx_valid = 1'b1; tx_data = 8'h5A; rx_ready = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (n < 8 && bus_rd && bus_addr == 3'd0) begin order[n] = 0; n++; end
         if (n < 8 && bus_wr && bus_addr == 3'd0) begin order[n] = 1; n++; end
      end
      checkOutput("alt_count", 16'(n >= 6), 16'd1);
      for (int i = 0; i < 6; i++)
         if (i < n) checkOutput($sformatf("alt_order%0d", i), 16'(order[i]), 16'(i % 2));
      for (int i = 0; i < 12 && !tx_ready; i++) step();
      step();
      tx_valid = 1'b0;

      // Sticky error from one LSR sample with FE set.
      waitPoll("err");
      lsr_model = 8'h69;
      step(); step(); step();
      lsr_model = 8'h60;
      checkOutput("err_set", 16'(err), 16'd1);
      checkOutput("err_bits_set", 16'(err_bits), 16'b0100);
      for (int i = 0; i < 20; i++) step();
      checkOutput("err_held", {11'd0, err, err_bits}, {11'd0, 1'b1, 4'b0100});

      // Reset in the middle of the configuration sequence.
      cfg_start = 1'b1; step(); cfg_start = 1'b0;
      step(); step();
      checkOutput("mid_cfg_dlm", {12'd0, bus_wr, bus_addr}, {12'd0, 1'b1, 3'd1});
      rst = 1'b1; step(); rst = 1'b0;
      checkResetState("mid_rst");
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus_rd || bus_wr) cnt++;
      end
      checkOutput("mid_rst_idle", 16'(cnt), 16'd0);

      // Restart from inside an RX read.
      applyStimulus(16'h0010, 7'h1B, 8'h00);
      lsr_model = 8'h61; rbr_model = 8'h77; rx_ready = 1'b0;
      step(); step(); step();
      checkOutput("abort_rx_rd", {12'd0, bus_rd, bus_addr}, {12'd0, 1'b1, 3'd0});
      step();
      checkOutput("abort_rx_w", {12'd0, bus_rd, bus_addr}, {12'd0, 1'b0, 3'd0});
      applyStimulus(16'($urandom), 7'($urandom), 8'($urandom));

      // Randomized polling against a poll-level service model.
      m_rx_full = 1'b0; m_rx_byte = 8'd0; m_credits = 16; m_last_tx = 1'b1; m_err = 4'd0;
      tx_valid = 1'b0; rx_ready = 1'b0;
      for (int it = 0; it < 200; it++) begin
         checkOutput("rnd_poll_start", {12'd0, bus_rd, bus_addr}, {12'd0, 1'b1, 3'd5});
         if (!(bus_rd && bus_addr == 3'd5)) waitPoll("rnd");
         checkOutput("rnd_rx_valid", 16'(rx_valid), 16'(m_rx_full));
         if (m_rx_full) checkOutput("rnd_rx_data", 16'(rx_data), 16'(m_rx_byte));
         rx_ready = 1'($urandom_range(0, 1));
         if (m_rx_full && rx_ready) m_rx_full = 1'b0;
         l = 8'($urandom);
         l[0] = 1'($urandom_range(0, 1));
         l[5] = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) != 0) l[4:1] = 4'd0;
         lsr_model = l;
         rbr_model = 8'($urandom);
         if (!tx_valid && $urandom_range(0, 2) != 0) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
         end
         tx_credit_ret = ($urandom_range(0, 2) == 0);
         if (tx_credit_ret && m_credits < 16) m_credits++;
         step();
         tx_credit_ret = 1'b0;
         step();
         m_err = m_err | l[4:1];
         rx_e = l[0] && !m_rx_full;
         tx_e = tx_valid && l[5] && (m_credits != 0);
         if (rx_e && tx_e) svc = m_last_tx ? 1 : 2;
         else if (rx_e) svc = 1;
         else if (tx_e) svc = 2;
         else svc = 0;
         step();
         if (svc == 1) begin
            checkOutput("rnd_rx_rd", {12'd0, bus_rd, bus_addr}, {12'd0, 1'b1, 3'd0});
            m_rx_full = 1'b1; m_rx_byte = l == 8'hxx ? 8'd0 : rbr_model; m_last_tx = 1'b0;
            step(); step(); step();
         end else if (svc == 2) begin
            checkOutput("rnd_tx_wr", {12'd0, bus_wr, tx_ready, bus_addr[1:0]}, 16'b1100);
            checkOutput("rnd_tx_data", 16'(bus_wdata), 16'(tx_data));
            m_credits--; m_last_tx = 1'b1;
            step();
            tx_valid = 1'b0;
         end
      end
      checkOutput("rnd_err_bits", 16'(err_bits), 16'(m_err));
      checkOutput("rnd_err", 16'(err), 16'(|m_err));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
